// File: rtl/grid_mem_arbiter.sv
// Arbitrates the single-port grid RAM between the game controller (A, read/write)
// and the display scanner (B, read-only), with a bounded A lock and read return.
module grid_mem_arbiter #(
    parameter logic [7:0] ADDR_MAX = 8'd251,
    parameter logic [3:0] LOCK_MAX = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_we,
    input  logic       a_lock,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic [7:0] b_addr,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       addr_err
);

    typedef enum logic [1:0] {PRIO_A, PRIO_B, LOCKED} state_t;

    localparam logic [7:0] BLOCK_BORDER = 8'h08;

    state_t     state_q, state_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic       a_pend_q, a_pend_d;
    logic       b_pend_q, b_pend_d;
    logic       rd_oor_q, rd_oor_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic       addr_err_q, addr_err_d;
    logic [7:0] sel_addr;
    logic       oor;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                PRIO_A: begin
                    if (a_req)      a_gnt = 1'b1;
                    else if (b_req) b_gnt = 1'b1;
                end
                PRIO_B: begin
                    if (b_req)      b_gnt = 1'b1;
                    else if (a_req) a_gnt = 1'b1;
                end
                LOCKED: begin
                    // A keeps the RAM until the lock budget is spent and B is waiting
                    if (b_req && lock_cnt_q == LOCK_MAX) b_gnt = 1'b1;
                    else if (a_req)                      a_gnt = 1'b1;
                    else if (b_req)                      b_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (a_gnt) begin
            if (a_lock) begin
                state_d    = LOCKED;
                lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
            end else begin
                state_d    = PRIO_B;
                lock_cnt_d = 4'd0;
            end
        end else if (b_gnt) begin
            state_d    = (state_q == LOCKED && a_lock) ? LOCKED : PRIO_A;
            lock_cnt_d = 4'd0;
        end else if (state_q == LOCKED && !a_lock) begin
            state_d    = PRIO_B;
            lock_cnt_d = 4'd0;
        end
    end

    always_comb begin
        sel_addr   = b_gnt ? b_addr : a_addr;
        oor        = (a_gnt || b_gnt) && (sel_addr > ADDR_MAX);
        mem_addr_d = mem_addr_q;
        mem_wdata  = 8'h00;
        mem_we     = 1'b0;
        if (a_gnt) begin
            mem_addr_d = a_addr;
            mem_wdata  = a_wdata;
            mem_we     = a_we && !oor;
        end else if (b_gnt) begin
            mem_addr_d = b_addr;
        end
    end

    assign mem_addr = mem_addr_d;

    // Read return: one grant per cycle, so a single out-of-range tag serves both ports
    always_comb begin
        a_pend_d   = a_gnt && !a_we;
        b_pend_d   = b_gnt;
        rd_oor_d   = oor;
        addr_err_d = addr_err_q || oor;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (a_pend_q) a_rdata_d = rd_oor_q ? BLOCK_BORDER : mem_rdata;
        if (b_pend_q) b_rdata_d = rd_oor_q ? BLOCK_BORDER : mem_rdata;
    end

    assign a_rvalid = a_pend_q;
    assign b_rvalid = b_pend_q;
    assign a_rdata  = a_rdata_d;
    assign b_rdata  = b_rdata_d;
    assign addr_err = addr_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PRIO_A;
            lock_cnt_q <= 4'd0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            rd_oor_q   <= 1'b0;
            a_rdata_q  <= 8'h00;
            b_rdata_q  <= 8'h00;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            a_pend_q   <= a_pend_d;
            b_pend_q   <= b_pend_d;
            rd_oor_q   <= rd_oor_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Idle address hold is pure data and needs no reset
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
    end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Bench for grid_mem_arbiter: vector tables with expected grants, plus a read-return
// scoreboard fed from a shadow copy of the grid RAM.
module tb_grid_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic       a_gnt, a_rvalid;
    logic [7:0] a_rdata;
    logic       b_req = 1'b0;
    logic [7:0] b_addr = 8'h00;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata = 8'h00;
    logic       addr_err;

    grid_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Grid RAM: 256 x 8, synchronous read with one cycle latency
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic       a_req, a_we, a_lock;
        logic [7:0] a_addr, a_wdata;
        logic       b_req;
        logic [7:0] b_addr;
        logic       ea, eb, ew;
    } vec_t;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } rd_t;

    vec_t       tbl[$];
    rd_t        sb[$];
    logic [7:0] exp_mem [256];
    logic [7:0] last_a, last_b, last_addr;
    logic       last_ok, exp_err;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t mk(input logic ar, input logic aw, input logic al,
                                input logic [7:0] aa, input logic [7:0] ad,
                                input logic br, input logic [7:0] ba,
                                input logic ea, input logic eb, input logic ew);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_addr = ba; v.ea = ea; v.eb = eb; v.ew = ew;
        return v;
    endfunction

    function automatic logic [7:0] rd_exp(input logic [7:0] addr);
        return (addr > 8'd251) ? 8'h08 : exp_mem[addr];
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        last_a  = 8'h00;
        last_b  = 8'h00;
        exp_err = 1'b0;
        last_ok = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; b_req = 1'b1;
        #2;
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; b_req = 1'b0;
        clear_model();
    endtask

    task automatic apply(input vec_t v);
        rd_t        e;
        logic       va, vb;
        logic [7:0] ga;
        a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock;
        a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_req = v.b_req; b_addr = v.b_addr;
        #3;
        va = 1'b0; vb = 1'b0;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            va = !e.port;
            vb = e.port;
            if (va) last_a = e.data;
            if (vb) last_b = e.data;
        end
        chk1("a_rvalid", a_rvalid, va);
        chk1("b_rvalid", b_rvalid, vb);
        chk8("a_rdata", a_rdata, last_a);
        chk8("b_rdata", b_rdata, last_b);
        chk1("a_gnt", a_gnt, v.ea);
        chk1("b_gnt", b_gnt, v.eb);
        chk1("mem_we", mem_we, v.ew);
        chk1("addr_err", addr_err, exp_err);
        chk8("mem_wdata", mem_wdata, v.ea ? v.a_wdata : 8'h00);
        ga = v.eb ? v.b_addr : v.a_addr;
        if (v.ea || v.eb) begin
            chk8("mem_addr", mem_addr, ga);
            last_addr = ga;
            last_ok   = 1'b1;
            if (ga > 8'd251) exp_err = 1'b1;
        end else if (last_ok) begin
            chk8("mem_addr_hold", mem_addr, last_addr);
        end
        if (v.ea && !v.a_we) sb.push_back('{1'b0, rd_exp(v.a_addr)});
        if (v.eb)            sb.push_back('{1'b1, rd_exp(v.b_addr)});
        if (v.ea && v.a_we && v.a_addr <= 8'd251) exp_mem[v.a_addr] = v.a_wdata;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_model();
        #1;
        do_reset();

        // Writes, read-back, idle hold
        tbl.delete();
        tbl.push_back(mk(1, 1, 0, 8'd17, 8'h03, 0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8'd5,  8'h44, 0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8'd30, 8'h1E, 0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8'd31, 8'h9C, 0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'd17, 8'hFF, 0, 8'd0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  8'h00, 0, 8'd0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Contention from reset alternates A, B, A, B
        do_reset();
        tbl.delete();
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 0, 8'd17, 8'h00, 1, 8'd5, (i % 2) == 0, (i % 2) == 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0, 8'h00, 0, 8'd0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Lock bound: 8 A grants, then B forced once, repeating
        do_reset();
        tbl.delete();
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(1, 0, 1, 8'd30, 8'h00, 1, 8'd31, !(i == 8 || i == 17), (i == 8 || i == 17), 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 8'd0, 8'h00, 0, 8'd0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd30, 8'h00, 1, 8'd31, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'd17, 8'h00, 0, 8'd0,  1, 0, 0));
        // Out-of-range accesses
        tbl.push_back(mk(0, 0, 0, 8'd0,   8'h00, 1, 8'd252, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'd255, 8'h77, 0, 8'd0,   1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd253, 8'h00, 0, 8'd0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 8'd0,   0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'd251, 8'h5B, 0, 8'd0,   1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'd251, 8'h00, 0, 8'd0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 8'd0,   0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Reset landing between an A read grant and its return
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 8'd17; b_req = 1'b0;
        #3;
        chk1("pre_rst_a_gnt", a_gnt, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("in_rst_a_gnt", a_gnt, 1'b0);
        chk1("in_rst_mem_we", mem_we, 1'b0);
        chk1("in_rst_a_rvalid", a_rvalid, 1'b0);
        @(posedge clk); #1;
        chk1("post_rst_a_rvalid", a_rvalid, 1'b0);
        reset = 1'b0;
        a_req = 1'b0;
        clear_model();
        tbl.delete();
        tbl.push_back(mk(0, 0, 0, 8'd0,  8'h00, 0, 8'd0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd17, 8'h00, 1, 8'd5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'd17, 8'h00, 1, 8'd5, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,  8'h00, 0, 8'd0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
- Shares the single-port tetris grid RAM (256 x 8, synchronous read, 1-cycle latency) between two requesters.
- Port A is the game-side requester: the grid controller FSM, with its piece-placer and line-clearer muxed behind it. It can read and write.
- Port B is the display scanner. It is read-only.
- The block does round-robin arbitration, supports a bounded lock for A's multi-cycle read-modify-write sequences, and routes read data back with a valid strobe.

Parameters:
- ADDR_MAX, 8'd251: highest legal grid address (game area 0-239 plus placement area 240-251).
- LOCK_MAX, 4'd8: maximum consecutive locked A grants before B is forced one grant.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  A requests an access this cycle.
- a_we  in  1  A access is a write.
- a_lock  in  1  A asks to keep ownership on following cycles.
- a_addr  in  8  A address.
- a_wdata  in  8  A write data.
- a_gnt  out  1  A access accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid.
- a_rdata  out  8  A read data.
- b_req  in  1  B read request.
- b_addr  in  8  B address.
- b_gnt  out  1  B access accepted this cycle (combinational).
- b_rvalid  out  1  B read data valid.
- b_rdata  out  8  B read data.
- mem_addr  out  8  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  8  RAM read data, valid the cycle after address.
- addr_err  out  1  sticky flag: a granted access had addr > ADDR_MAX.

Behaviour:
- Reset (async, any cycle, mid-access included):
  - state = PRIO_A; lock_cnt = 0.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0; addr_err = 0.
  - Grants are forced to 0 and mem_we = 0 while reset is high.
  - Read returns in flight are discarded, with no rvalid after release.
- Exactly one grant per cycle at most. A grant is issued only to a requester whose req is high.
- State machine (registered):
  - PRIO_A: if a_req, grant A. Else if b_req, grant B.
  - PRIO_B: if b_req, grant B. Else if a_req, grant A.
  - LOCKED: A has priority unconditionally. The one exception is lock_cnt == LOCK_MAX with b_req high: B is granted and lock_cnt clears.
- Transitions:
  - A granted with a_lock=1 -> LOCKED, lock_cnt += 1 (saturating at LOCK_MAX).
  - A granted with a_lock=0 -> PRIO_B, lock_cnt = 0.
  - B granted -> PRIO_A. If a_lock is still high, B granted from LOCKED returns to LOCKED with lock_cnt = 0.
  - No grant: from LOCKED with a_lock=0 -> PRIO_B; otherwise state holds.
  - Entering LOCKED counts the first locked grant as 1. LOCK_MAX consecutive locked A grants are allowed before a yield.
- Memory drive (combinational from grant):
  - Granted A: mem_addr = a_addr, mem_wdata = a_wdata, mem_we = a_we.
  - Granted B: mem_addr = b_addr, mem_we = 0.
  - No grant: mem_we = 0, mem_addr holds last value (registered copy).
  - mem_wdata = 0 when B is granted or there is no grant.
- Read return:
  - A granted read at cycle t -> a_rvalid = 1 at t+1 with a_rdata = mem_rdata.
  - Likewise for B. rvalid is a single-cycle pulse.
  - rdata registers hold their last value when rvalid is low.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. Read data for consecutive grants pipelines with 1-cycle offset.
- Out-of-range address (addr > ADDR_MAX) on a granted access:
  - mem_we is forced 0.
  - The read still returns rvalid at t+1, with rdata = 8'h08 (BLOCK_BORDER) so collision logic treats it as solid.
  - addr_err sets and stays set until reset.
- Requesters must hold req/addr/data stable until gnt is seen. The arbiter does not queue requests.

Test Plan:
- Single A write then read: a_req, a_we=1, addr=8'd17, wdata=8'h03 at t0 -> a_gnt=1, mem_we=1 at t0. Read addr 17 at t1 -> a_rvalid=1, a_rdata=8'h03 at t2.
- Contention fairness: a_req=b_req=1 continuously, a_lock=0, from reset -> grants alternate A,B,A,B. Each rvalid arrives one cycle after its grant, on the correct port.
- Lock bound: a_lock=1, a_req=1, b_req=1 for 20 cycles, LOCK_MAX=8 -> 8 A grants, 1 B grant, 8 A grants, 1 B grant. lock_cnt never exceeds 8.
- Out-of-range: B reads addr 8'd252 -> mem_we=0, b_rvalid=1, b_rdata=8'h08 next cycle, addr_err=1 sticky. A write to 8'd255 -> mem_we stays 0.
- Reset mid-read: A read granted at t0, reset asserted asynchronously before the t1 edge -> a_rvalid stays 0, state=PRIO_A. The first post-reset contention grants A.
- Idle: no requests for 10 cycles -> no grants, mem_we=0, no rvalid. State is unchanged except LOCKED with a_lock=0 -> PRIO_B.
